// File: rtl/rif_rd_arbiter.sv
// rif_rd_arbiter
//   Shares the LMAC register-read port between N requesters on the fmac_clk
//   side. One pending request is chosen round-robin, its address and a start
//   pulse go to the LMAC, and the read data (or ERR_DATA when the watchdog
//   expires) is returned to the winner with a one-cycle response pulse.
//
// Ports
//   fmac_clk          block clock
//   reset             asynchronous, active-high reset
//   req[N]            per-requester read request level, held until rsp_valid
//   req_addr[N*AW]    packed addresses, requester i uses [i*AW +: AW]
//   gnt[N]            one-hot grant pulse
//   rsp_valid[N]      one-hot response pulse
//   rsp_data[DW]      read data, valid with rsp_valid, held until next response
//   rsp_err           timeout flag, valid with rsp_valid
//   host_addr_out     LMAC address, held from grant through response
//   reg_rd_start_out  one-cycle LMAC start pulse
//   mac_regdout_in    LMAC read data, sampled with reg_rd_done_in
//   reg_rd_done_in    LMAC read-complete pulse
//   busy              high whenever a transaction is in progress
module rif_rd_arbiter #(
  parameter int N       = 3,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_DEAD)
) (
  input  logic            fmac_clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic [AW-1:0]   host_addr_out,
  output logic            reg_rd_start_out,
  input  logic [DW-1:0]   mac_regdout_in,
  input  logic            reg_rd_done_in,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  // Timer only has to reach TIMEOUT-1
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;

  // Index base+off modulo N, without relying on N being a power of two
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  function automatic logic [N-1:0] one_hot(input logic [PW-1:0] idx);
    return N'(1) << idx;
  endfunction

  // Round-robin pick: first asserted request scanning upward from rr_ptr
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 0; off < N; off++) begin
      cand = wrap_add(rr_ptr_q, off);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below, so
  // the pulses here land one cycle after the edge that decides them.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    timer_d     = timer_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    start_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          gnt_d   = one_hot(pick_idx);
          addr_d  = req_addr[int'(pick_idx)*AW +: AW];
          start_d = 1'b1;
          timer_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the timeout edge still returns real data
        if (reg_rd_done_in) begin
          rsp_data_d  = mac_regdout_in;
          rsp_err_d   = 1'b0;
          rsp_valid_d = one_hot(win_q);
          state_d     = RESP;
        end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d  = ERR_DATA;
          rsp_err_d   = 1'b1;
          rsp_valid_d = one_hot(win_q);
          state_d     = RESP;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        rr_ptr_d = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge fmac_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      timer_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt              = gnt_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_err          = rsp_err_q;
  assign host_addr_out    = addr_q;
  assign reg_rd_start_out = start_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_rif_rd_arbiter.sv
// tb_rif_rd_arbiter
//   Bench for rif_rd_arbiter with N=3 and a short watchdog (TIMEOUT=8).
//   The bench plays the LMAC: it raises done a chosen number of WAIT cycles
//   after the grant and returns either fixed data or data tagged with the
//   address it was given.
module tb_rif_rd_arbiter;

  localparam int N       = 3;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic            fmac_clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic [AW-1:0]   host_addr_out;
  logic            reg_rd_start_out;
  logic [DW-1:0]   mac_regdout_in;
  logic            reg_rd_done_in;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int model_rr;

  localparam logic [N*AW-1:0] ADDRS = {16'h0208, 16'h0104, 16'h0040};

  rif_rd_arbiter #(
    .N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_DEAD)
  ) dut (
    .fmac_clk(fmac_clk),
    .reset(reset),
    .req(req),
    .req_addr(req_addr),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .host_addr_out(host_addr_out),
    .reg_rd_start_out(reg_rd_start_out),
    .mac_regdout_in(mac_regdout_in),
    .reg_rd_done_in(reg_rd_done_in),
    .busy(busy)
  );

  always #5 fmac_clk = ~fmac_clk;

  typedef struct {
    logic [N-1:0]  req;
    int            d;
    logic          use_fixed;
    logic [DW-1:0] data;
    logic [N-1:0]  exp_gnt;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference arbitration: rotate the request vector so rr sits at bit 0,
  // take the lowest set bit, and rotate the answer back.
  function automatic int model_winner(input logic [N-1:0] r, input int rr);
    logic [2*N-1:0] dbl;
    dbl = {r, r} >> rr;
    for (int p = 0; p < N; p++)
      if (dbl[p]) return (rr + p) % N;
    return -1;
  endfunction

  // One complete read. d is the WAIT cycle on whose closing edge done is
  // high (1 = first WAIT edge); d=0 means the LMAC never answers.
  // Called and returns at a falling edge with the DUT idle.
  task automatic apply_stimulus(
    input logic [N-1:0]    r,
    input logic [N*AW-1:0] addrs,
    input int              d,
    input logic            use_fixed,
    input logic [DW-1:0]   fixed_data,
    input logic            drop_req,
    input logic [N-1:0]    exp_gnt,
    input logic [AW-1:0]   exp_addr,
    input logic [DW-1:0]   exp_data,
    input logic            exp_err
  );
    int   lat;
    int   exp_lat;
    logic got;
    req      = r;
    req_addr = addrs;
    got      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge fmac_clk);
      if (gnt != '0) begin
        got = 1'b1;
        break;
      end
    end
    check_output("grant_seen", 32'(got), 32'd1);
    if (!got) begin
      req = '0;
      return;
    end
    check_output("gnt", 32'(gnt), 32'(exp_gnt));
    check_output("start_at_grant", 32'(reg_rd_start_out), 32'd1);
    check_output("host_addr_at_grant", 32'(host_addr_out), 32'(exp_addr));
    check_output("busy_at_grant", 32'(busy), 32'd1);

    got = 1'b0;
    lat = 0;
    for (int i = 0; i < TIMEOUT + 12; i++) begin
      @(negedge fmac_clk);
      lat++;
      if (rsp_valid != '0) begin
        got = 1'b1;
        break;
      end
      if (lat == 1) begin
        check_output("start_one_cycle", 32'(reg_rd_start_out), 32'd0);
        check_output("gnt_one_cycle", 32'(gnt), 32'd0);
        if (drop_req) req = '0;
      end
      if (d != 0 && lat == d) begin
        reg_rd_done_in = 1'b1;
        mac_regdout_in = use_fixed ? fixed_data : {16'hDA7A, host_addr_out};
      end else begin
        reg_rd_done_in = 1'b0;
      end
    end
    reg_rd_done_in = 1'b0;
    check_output("rsp_seen", 32'(got), 32'd1);
    exp_lat = (d != 0 && d <= TIMEOUT) ? d + 1 : TIMEOUT + 1;
    check_output("rsp_latency", 32'(lat), 32'(exp_lat));
    check_output("rsp_valid", 32'(rsp_valid), 32'(exp_gnt));
    check_output("rsp_data", rsp_data, exp_data);
    check_output("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_output("host_addr_held", 32'(host_addr_out), 32'(exp_addr));
    check_output("busy_in_resp", 32'(busy), 32'd1);
    req = '0;
    @(negedge fmac_clk);
    check_output("rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);
    check_output("busy_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0]    eg;
    logic [N*AW-1:0] ra;
    logic [DW-1:0]   rd;
    logic            ee;
    logic            regrant;
    int              w;
    int              d;

    // Request pattern, done cycle, data source, expected winner/addr/data/err.
    // Winners follow the pointer: 0 -> 1 -> 2 -> 0 -> 2 -> 1 -> 0 -> 1.
    vecs[0] = '{3'b001, 3, 1'b1, 32'h1234_5678, 3'b001, 16'h0040, 32'h1234_5678, 1'b0};
    vecs[1] = '{3'b111, 2, 1'b0, 32'h0,         3'b010, 16'h0104, 32'hDA7A_0104, 1'b0};
    vecs[2] = '{3'b111, 2, 1'b0, 32'h0,         3'b100, 16'h0208, 32'hDA7A_0208, 1'b0};
    vecs[3] = '{3'b111, 2, 1'b0, 32'h0,         3'b001, 16'h0040, 32'hDA7A_0040, 1'b0};
    vecs[4] = '{3'b101, 1, 1'b0, 32'h0,         3'b100, 16'h0208, 32'hDA7A_0208, 1'b0};
    vecs[5] = '{3'b010, 0, 1'b0, 32'h0,         3'b010, 16'h0104, 32'hDEAD_DEAD, 1'b1};
    vecs[6] = '{3'b011, 8, 1'b1, 32'hCAFE_0001, 3'b001, 16'h0040, 32'hCAFE_0001, 1'b0};
    vecs[7] = '{3'b110, 9, 1'b1, 32'hBEEF_0002, 3'b010, 16'h0104, 32'hDEAD_DEAD, 1'b1};

    reset          = 1'b1;
    req            = '0;
    req_addr       = '0;
    mac_regdout_in = '0;
    reg_rd_done_in = 1'b0;
    repeat (3) @(negedge fmac_clk);
    check_output("reset_gnt", 32'(gnt), 32'd0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_rsp_data", rsp_data, 32'd0);
    check_output("reset_rsp_err", 32'(rsp_err), 32'd0);
    check_output("reset_host_addr", 32'(host_addr_out), 32'd0);
    check_output("reset_start", 32'(reg_rd_start_out), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge fmac_clk);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].req, ADDRS, vecs[i].d, vecs[i].use_fixed, vecs[i].data,
                     1'b0, vecs[i].exp_gnt, vecs[i].exp_addr, vecs[i].exp_data,
                     vecs[i].exp_err);
    end

    // Spurious done while idle must leave everything alone
    reg_rd_done_in = 1'b1;
    mac_regdout_in = 32'h5555_5555;
    @(negedge fmac_clk);
    reg_rd_done_in = 1'b0;
    check_output("spurious_rsp_data", rsp_data, 32'hDEAD_DEAD);
    check_output("spurious_rsp_err", 32'(rsp_err), 32'd1);
    check_output("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("spurious_busy", 32'(busy), 32'd0);
    check_output("spurious_start", 32'(reg_rd_start_out), 32'd0);
    check_output("spurious_host_addr", 32'(host_addr_out), 32'h0104);
    @(negedge fmac_clk);

    // Requester 1 withdraws right after its grant (pointer is at 2)
    apply_stimulus(3'b010, ADDRS, 2, 1'b0, 32'h0, 1'b1, 3'b010, 16'h0104, 32'hDA7A_0104, 1'b0);
    regrant = 1'b0;
    repeat (4) begin
      @(negedge fmac_clk);
      if (gnt != '0) regrant = 1'b1;
    end
    check_output("withdraw_no_regrant", 32'(regrant), 32'd0);

    // Reset mid-WAIT aborts; pointer (2 before) must return to 0
    req = 3'b100;
    regrant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge fmac_clk);
      if (gnt != '0) begin
        regrant = 1'b1;
        break;
      end
    end
    check_output("abort_grant_seen", 32'(regrant), 32'd1);
    check_output("abort_gnt", 32'(gnt), 32'b100);
    repeat (2) @(negedge fmac_clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort_async_busy", 32'(busy), 32'd0);
    check_output("abort_async_host_addr", 32'(host_addr_out), 32'd0);
    check_output("abort_async_rsp_data", rsp_data, 32'd0);
    check_output("abort_async_rsp_err", 32'(rsp_err), 32'd0);
    check_output("abort_async_gnt_start", 32'({gnt, reg_rd_start_out}), 32'd0);
    @(negedge fmac_clk);
    check_output("abort_no_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    apply_stimulus(3'b110, ADDRS, 2, 1'b0, 32'h0, 1'b0, 3'b010, 16'h0104, 32'hDA7A_0104, 1'b0);
    model_rr = 2;

    // Randomised reads against the reference model
    for (int t = 0; t < 30; t++) begin
      eg = N'($urandom_range(1, 7));
      ra = (N*AW)'({$urandom(), $urandom()});
      d  = int'($urandom_range(0, TIMEOUT + 2));
      rd = $urandom();
      w  = model_winner(eg, model_rr);
      ee = !(d != 0 && d <= TIMEOUT);
      apply_stimulus(eg, ra, d, 1'b1, rd, 1'($urandom_range(0, 1)),
                     N'(1) << w, ra[w*AW +: AW], ee ? 32'hDEAD_DEAD : rd, ee);
      model_rr = (w + 1) % N;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rif_rd_arbiter.md
Name: rif_rd_arbiter

Overview:
- Single-clock controller that shares the LMAC register-read port between N requesters, e.g. the host bridge path, a statistics poller and a debug port.
- Picks one request by round-robin, drives address and start toward the LMAC, waits for done, and returns read data to the winner.
- A watchdog terminates any read the LMAC never completes.
- Sits on the fmac_clk side, between requester logic and the LMAC register interface.

Parameters:
- N, 3, number of requesters (2..8).
- AW, 16, register address width.
- DW, 32, read data width.
- TIMEOUT, 64, fmac_clk cycles to wait for done; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_DEAD, value returned on timeout.

Ports:
- fmac_clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-requester read request level; held until its rsp_valid.
- req_addr  in  N*AW  packed addresses; requester i uses bits [i*AW +: AW].
- gnt  out  N  one-hot grant pulse, one cycle.
- rsp_valid  out  N  one-hot response pulse, one cycle.
- rsp_data  out  DW  read data; valid while rsp_valid is non-zero.
- rsp_err  out  1  timeout flag; valid with rsp_valid.
- host_addr_out  out  AW  address to the LMAC; held from grant through response.
- reg_rd_start_out  out  1  one-cycle start pulse to the LMAC.
- mac_regdout_in  in  DW  LMAC read data; sampled when reg_rd_done_in is high.
- reg_rd_done_in  in  1  LMAC read-complete pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, high): state=IDLE, rr_ptr=0, timer=0. All outputs are 0 (gnt, rsp_valid, rsp_data, rsp_err, host_addr_out, reg_rd_start_out, busy). All outputs are registered.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE: at any edge where req!=0, select the winner w.
  - w is the first asserted req scanning upward from index rr_ptr, wrapping N-1 -> 0.
  - Next cycle: state=ISSUE, gnt[w]=1, host_addr_out=req_addr[w], reg_rd_start_out=1, timer=0.
- ISSUE: lasts exactly one cycle. Next state is WAIT; gnt and reg_rd_start_out return to 0.
- WAIT:
  - Each edge with reg_rd_done_in=1: rsp_data<=mac_regdout_in, rsp_err<=0, go to RESP.
  - Otherwise timer increments. When TIMEOUT!=0 and timer==TIMEOUT-1: rsp_data<=ERR_DATA, rsp_err<=1, go to RESP.
  - If done arrives on the same edge as the timeout, done wins: real data is returned and rsp_err=0.
- RESP: rsp_valid[w]=1 for one cycle; rsp_data and rsp_err are held.
  - rr_ptr<=(w+1) mod N.
  - Next state is IDLE. rsp_data and rsp_err hold until the next RESP.
- Latency: with req sampled at edge 0 and done high at edge k (k>=2), rsp_valid is high in cycle k+1. The next grant comes at the earliest 2 cycles after RESP begins, because IDLE is always visited.
- If a requester drops req after its grant, the read still completes and rsp_valid still pulses. The requester is not re-granted unless req is asserted again.
- req_addr is sampled only at the grant edge; later changes are ignored.
- reg_rd_done_in is ignored in IDLE, ISSUE and RESP. A spurious done changes no state or output.
- The timer is wide enough for TIMEOUT-1 and never wraps; it is cleared on every grant.
- Reset asserted mid-WAIT aborts the transaction: no rsp_valid is issued and rr_ptr returns to 0.
- host_addr_out keeps its last value in IDLE.

Test Plan:
- Single read: req=3'b001, req_addr[0]=16'h0040; LMAC returns done with 32'h1234_5678 three cycles after start -> one start pulse, host_addr_out=16'h0040, rsp_valid=3'b001 with rsp_data=32'h1234_5678, rsp_err=0, busy low in the following cycle.
- Fairness: req=3'b111 held, LMAC done 2 cycles after each start -> grant order 0,1,2,0; each rsp_valid is one-hot and its rsp_data matches that requester's address-tagged data.
- Timeout: TIMEOUT=8, LMAC never responds -> rsp_valid pulses in cycle 8 after WAIT entry with rsp_data=32'hDEAD_DEAD and rsp_err=1; rr_ptr advances.
- Collision: done asserted on the exact timeout edge with data 32'hCAFE_0001 -> rsp_data=32'hCAFE_0001, rsp_err=0, exactly one rsp_valid.
- Spurious and abort:
  - done pulsed in IDLE -> no output change.
  - reset pulsed mid-WAIT -> all outputs 0 asynchronously, no rsp_valid, the next grant goes to the lowest asserted index.
- Request withdrawal: req[1] dropped one cycle after gnt[1] -> rsp_valid[1] still pulses and requester 1 is not re-granted.
